fp_div_16: RTL and testbench
============================

Name: fp_div_16

Overview:
- Iterative IEEE-754 binary16 divider (Quotient = A / B). It is the inverse-operation companion to the pipelined FP16 multiplier in the PE datapath.
- Uses one restoring-division step per cycle on the 11-bit significands, plus exponent subtract and normalize.
- valid/ready handshake on both sides. One operation in flight at a time.
- Sits beside the multiplier in the PE for normalization/scaling ops.

Parameters:
- none (the format is fixed at binary16; behaviour is selected by the macro below)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset: asynchronous, active-high
- in_valid  in  1  operands A/B valid
- in_ready  out  1  divider can accept operands (high only in IDLE)
- A  in  16  dividend, binary16
- B  in  16  divisor, binary16
- out_valid  out  1  Quotient valid
- out_ready  in  1  downstream accepts Quotient
- Quotient  out  16  result, binary16

Behaviour:
- Reset (asynchronous, any time, including mid-division):
  - FSM goes to IDLE.
  - Quotient=16'h0000, out_valid=0, in_ready=1 (after release). Iteration counter and remainder are cleared.
- Unpack: s=A[15]^B[15]; eA/eB=[14:10]; significand={1,[9:0]}.
  - Any operand with exponent 0 is treated as zero (subnormal flush).
  - Exponent 31 is not special-cased; it is treated as finite.
- Special cases, resolved at accept with no iterations:
  - A zero and B zero -> 16'h7E00.
  - B zero only -> {s,5'h1F,10'h0}.
  - A zero only -> 16'h0000.
- FSM states IDLE, DIV, DONE:
  - IDLE: in_ready=1. On in_valid, latch operands and go to DIV; if a special case applies, go directly to DONE.
  - DIV: one iteration per cycle, N iterations (N=12, or 13 with the macro). Then go to DONE.
  - DONE: out_valid=1. Quotient is held stable while out_ready=0. When out_valid&out_ready, go to IDLE on the next cycle.
- Latency:
  - Normal operation: out_valid rises N+1 cycles after the accept edge.
  - Special case: out_valid rises 1 cycle after the accept edge.
  - Throughput: one op per N+2 cycles minimum.
- Iteration step:
  - R initialised to mA (12-bit). Each cycle: if R>=mB, shift a 1 into q and set R=R-mB; else shift a 0 into q. Then R=R<<1.
  - The first quotient bit is the integer bit.
- Exponent:
  - e = eA - eB + 15, 7-bit signed.
  - If the integer bit is 1: mantissa = the 10 bits after the integer bit, e_f = e.
  - Else: mantissa = bits 2..11 after the integer bit, e_f = e-1.
- Clamp:
  - e_f <= 0 -> Quotient=16'h0000.
  - e_f >= 31 -> saturate to {s,5'h1E,10'h3FF}.
  - Otherwise Quotient={s,e_f[4:0],mantissa}.
- in_valid while busy is ignored (no accept). in_valid and out handshake in the same DONE cycle: the new operand is not accepted until IDLE.

Optional Feature:
- Macro FP_DIV_ROUND_NEAREST_EN.
- Defined:
  - N=13; the extra quotient bit is the guard bit, sticky = (R!=0).
  - Round-to-nearest-even: increment when guard & (sticky | mantissa LSB).
  - A mantissa carry-out sets mantissa=0 and e_f+1. The overflow clamp is applied after rounding.
- Undefined: N=12, truncation, no rounding hardware.

Test Plan:
- A=16'h3C00, B=16'h3C00 (1/1) -> Quotient=16'h3C00. out_valid exactly N+1 cycles after accept.
- A=16'h4200, B=16'h4000 (3/2) -> 16'h3E00. A=16'hC600, B=16'h4000 (-6/2) -> 16'hC200.
- A=16'h3C00, B=16'h4200 (1/3) -> 16'h3555, in both macro builds (guard bit 0).
- Special cases (1-cycle latency):
  - A=16'h4000, B=16'h0000 -> 16'h7C00.
  - A=16'h0000, B=16'h0000 -> 16'h7E00.
  - A=16'h0000, B=16'h4000 -> 16'h0000.
- Clamps:
  - A=16'h7BFF, B=16'h0400 -> 16'h7BFF (overflow saturate).
  - A=16'h0400, B=16'h7BFF -> 16'h0000 (underflow).
- Control:
  - Hold out_ready=0 for 5 cycles in DONE -> Quotient and out_valid stable, in_ready=0.
  - Assert rst 4 cycles into DIV -> immediate out_valid=0, Quotient=0. Next op after release returns the correct result.

Source files
------------

// File: rtl/fp_div_16.sv
// fp_div_16: iterative IEEE-754 binary16 divider (Quotient = A / B).
// One restoring-division step per cycle on the 11-bit significands.
// Exponent subtraction, normalisation and clamping are done on the final step.
// Optional macro FP_DIV_ROUND_NEAREST_EN: when it is defined, a 13th (guard)
// quotient bit is produced and the result is rounded to nearest-even.
// In the default build 12 quotient bits are produced and the result is truncated.
//
// state | meaning
// IDLE  | ready for operands
// DIV   | one quotient bit per cycle
// DONE  | result presented, waiting for out_ready
module fp_div_16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] A,
  input  logic [15:0] B,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] Quotient
);

`ifdef FP_DIV_ROUND_NEAREST_EN
  localparam int N = 13;
`else
  localparam int N = 12;
`endif
  localparam logic [3:0] LAST = 4'(N - 1);

  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [11:0]       rem_q, rem_d;
  logic [N-1:0]      quo_q, quo_d;
  logic [10:0]       mb_q, mb_d;
  logic signed [6:0] exp_q, exp_d;
  logic              sign_q, sign_d;
  logic [15:0]       res_q, res_d;

  logic              a_zero, b_zero, s_in;
  logic signed [6:0] exp_in;
  logic              rem_ge;
  logic [11:0]       rem_sub, rem_nx;
  logic [N-1:0]      quo_nx;
  logic [9:0]        man;
  logic signed [7:0] e_f;
  logic [15:0]       pack_res;
`ifdef FP_DIV_ROUND_NEAREST_EN
  logic              guard, sticky;
  logic [10:0]       man_rnd;
`endif

  // Exponent 0 flushes to zero; exponent 31 is treated as an ordinary finite value.
  assign a_zero = (A[14:10] == 5'd0);
  assign b_zero = (B[14:10] == 5'd0);
  assign s_in   = A[15] ^ B[15];
  assign exp_in = $signed({2'b00, A[14:10]}) - $signed({2'b00, B[14:10]}) + 7'sd15;

  // One restoring step: compare, conditionally subtract, shift the quotient bit in.
  assign rem_ge  = (rem_q >= {1'b0, mb_q});
  assign rem_sub = rem_ge ? (rem_q - {1'b0, mb_q}) : rem_q;
  assign rem_nx  = rem_sub << 1;
  assign quo_nx  = (quo_q << 1) | {{(N-1){1'b0}}, rem_ge};

  // Normalise the final quotient, optionally round, then clamp into binary16.
  always_comb begin
    man      = '0;
    e_f      = '0;
    pack_res = '0;
`ifdef FP_DIV_ROUND_NEAREST_EN
    guard   = 1'b0;
    sticky  = 1'b0;
    man_rnd = '0;
    if (quo_nx[N-1]) begin
      man    = quo_nx[N-2:N-11];
      guard  = quo_nx[1];
      sticky = quo_nx[0] | (rem_nx != 12'd0);
      e_f    = {exp_q[6], exp_q};
    end else begin
      man    = quo_nx[N-3:N-12];
      guard  = quo_nx[0];
      sticky = (rem_nx != 12'd0);
      e_f    = {exp_q[6], exp_q} - 8'sd1;
    end
    man_rnd = {1'b0, man} + {10'd0, guard & (sticky | man[0])};
    man     = man_rnd[9:0];
    if (man_rnd[10]) e_f = e_f + 8'sd1;
`else
    if (quo_nx[N-1]) begin
      man = quo_nx[N-2:N-11];
      e_f = {exp_q[6], exp_q};
    end else begin
      man = quo_nx[N-3:0];
      e_f = {exp_q[6], exp_q} - 8'sd1;
    end
`endif
    if (e_f <= 8'sd0)       pack_res = 16'h0000;
    else if (e_f >= 8'sd31) pack_res = {sign_q, 5'h1E, 10'h3FF};
    else                    pack_res = {sign_q, e_f[4:0], man};
  end

  // Next-state logic: accept and resolve special cases, iterate, hand off the result.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    mb_d    = mb_q;
    exp_d   = exp_q;
    sign_d  = sign_q;
    res_d   = res_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d = s_in;
          exp_d  = exp_in;
          mb_d   = {1'b1, B[9:0]};
          rem_d  = {1'b0, 1'b1, A[9:0]};
          quo_d  = '0;
          cnt_d  = '0;
          if (a_zero && b_zero) begin
            res_d   = 16'h7E00;
            state_d = DONE;
          end else if (b_zero) begin
            res_d   = {s_in, 5'h1F, 10'h000};
            state_d = DONE;
          end else if (a_zero) begin
            res_d   = 16'h0000;
            state_d = DONE;
          end else begin
            state_d = DIV;
          end
        end
      end
      DIV: begin
        rem_d = rem_nx;
        quo_d = quo_nx;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == LAST) begin
          res_d   = pack_res;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset may land at any time, including mid-division.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      mb_q    <= '0;
      exp_q   <= '0;
      sign_q  <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      mb_q    <= mb_d;
      exp_q   <= exp_d;
      sign_q  <= sign_d;
      res_q   <= res_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign Quotient  = res_q;

endmodule

// File: tb/tb_fp_div_16.sv
// Scoreboard bench for fp_div_16: the driver pushes the expected quotient and
// latency when an operand pair is accepted; the monitor pops and compares
// whenever a result is handed off, and checks reset and stall behaviour.
module tb_fp_div_16;

`ifdef FP_DIV_ROUND_NEAREST_EN
  localparam int N = 13;
`else
  localparam int N = 12;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [15:0] a_in = '0;
  logic [15:0] b_in = '0;
  logic        in_ready, out_valid;
  logic [15:0] quotient;

  fp_div_16 dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(a_in), .B(b_in), .out_valid(out_valid), .out_ready(out_ready),
    .Quotient(quotient)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] q;
    logic [15:0] a;
    logic [15:0] b;
    int          acc;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  exp_t        cur;
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          rise_cyc = 0;
  logic        prev_ov = 1'b0;
  logic        prev_stall = 1'b0;
  logic        done_req = 1'b0;
  logic [15:0] ra, rb;

  // Reference: exact rational division of the significands with integer arithmetic.
  function automatic logic [15:0] model(input logic [15:0] a, input logic [15:0] b);
    logic s;
    int ea, eb, ma, mb, e, num, man, rem;
    s  = a[15] ^ b[15];
    ea = int'(a[14:10]);
    eb = int'(b[14:10]);
    ma = 1024 + int'(a[9:0]);
    mb = 1024 + int'(b[9:0]);
    if (ea == 0 && eb == 0) return 16'h7E00;
    if (eb == 0) return {s, 5'h1F, 10'h000};
    if (ea == 0) return 16'h0000;
    e = ea - eb + 15;
    if (ma >= mb) begin
      num = ma * 1024;
    end else begin
      num = ma * 2048;
      e   = e - 1;
    end
    man = num / mb - 1024;
    rem = num % mb;
`ifdef FP_DIV_ROUND_NEAREST_EN
    if (2 * rem > mb || (2 * rem == mb && (man % 2) == 1)) man = man + 1;
    if (man == 1024) begin
      man = 0;
      e   = e + 1;
    end
`endif
    if (e <= 0) return 16'h0000;
    if (e >= 31) return {s, 5'h1E, 10'h3FF};
    return {s, e[4:0], man[9:0]};
  endfunction

  task automatic send(input logic [15:0] a, input logic [15:0] b);
    int guard_cnt;
    guard_cnt = 0;
    @(posedge clk); #1;
    while (!in_ready) begin
      @(posedge clk); #1;
      guard_cnt++;
      if (guard_cnt > 200) begin
        $display("FAIL send_timeout: in_ready stayed 0, required 1 within 200 cycles");
        $fatal(1);
      end
    end
    a_in     = a;
    b_in     = b;
    in_valid = 1'b1;
    @(posedge clk);
    sb.push_back('{q: model(a, b), a: a, b: b, acc: cyc,
                   lat: ((a[14:10] == 5'd0 || b[14:10] == 5'd0) ? 1 : N + 1)});
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int guard_cnt;
    guard_cnt = 0;
    @(posedge clk); #1;
    while (sb.size() != 0 || !in_ready) begin
      @(posedge clk); #1;
      guard_cnt++;
      if (guard_cnt > 200) begin
        $display("FAIL idle_timeout: %0d results pending, required 0 within 200 cycles", sb.size());
        $fatal(1);
      end
    end
  endtask

  task automatic wait_valid();
    int guard_cnt;
    guard_cnt = 0;
    @(posedge clk); #1;
    while (!out_valid) begin
      @(posedge clk); #1;
      guard_cnt++;
      if (guard_cnt > 200) begin
        $display("FAIL valid_timeout: out_valid stayed 0, required 1 within 200 cycles");
        $fatal(1);
      end
    end
  endtask

  // Monitor: samples on the falling edge, away from the DUT's active edge.
  always @(negedge clk) begin
    if (rst) begin
      checks++;
      if (out_valid !== 1'b0 || quotient !== 16'h0000 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL reset_state: out_valid=%0b Quotient=%h in_ready=%0b, required 0/0000/1",
                 out_valid, quotient, in_ready);
      end
      sb.delete();
      prev_ov    = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checks++;
        if (out_valid !== 1'b1) begin
          errors++;
          $display("FAIL stall_hold: out_valid=%0b while out_ready=0, required 1", out_valid);
        end
      end
      if (out_valid && !prev_ov) rise_cyc = cyc;
      if (out_valid && !out_ready) begin
        checks++;
        if (in_ready !== 1'b0) begin
          errors++;
          $display("FAIL stall_in_ready: in_ready=%0b in DONE, required 0", in_ready);
        end
        if (sb.size() > 0) begin
          checks++;
          if (quotient !== sb[0].q) begin
            errors++;
            $display("FAIL stall_value: Quotient=%h, required %h", quotient, sb[0].q);
          end
        end
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: Quotient=%h with no operation outstanding", quotient);
        end else begin
          cur = sb.pop_front();
          checks++;
          if (quotient !== cur.q) begin
            errors++;
            $display("FAIL quotient A=%h B=%h: got %h, required %h", cur.a, cur.b, quotient, cur.q);
          end
          checks++;
          if (rise_cyc - cur.acc + 1 != cur.lat) begin
            errors++;
            $display("FAIL latency A=%h B=%h: got %0d cycles, required %0d",
                     cur.a, cur.b, rise_cyc - cur.acc + 1, cur.lat);
          end
        end
      end
      prev_ov    = out_valid;
      prev_stall = out_valid && !out_ready;
      if (done_req) begin
        checks++;
        if (sb.size() != 0) begin
          errors++;
          $display("FAIL drain: %0d results outstanding, required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
      end
    end
    cyc++;
  end

  initial begin
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    send(16'h3C00, 16'h3C00);
    send(16'h4200, 16'h4000);
    send(16'hC600, 16'h4000);
    send(16'h3C00, 16'h4200);
    send(16'h4000, 16'h0000);
    send(16'h0000, 16'h0000);
    send(16'h0000, 16'h4000);
    send(16'h7BFF, 16'h0400);
    send(16'h0400, 16'h7BFF);

    // Result held for 5 cycles with out_ready low; a request in that window is ignored.
    wait_idle();
    out_ready = 1'b0;
    send(16'h4400, 16'h3C00);
    wait_valid();
    a_in     = 16'h1234;
    b_in     = 16'h5678;
    in_valid = 1'b1;
    repeat (5) @(posedge clk);
    #1 in_valid = 1'b0;
    out_ready = 1'b1;

    // Reset four cycles into the iteration, then a clean operation afterwards.
    wait_idle();
    send(16'h4500, 16'h3C00);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    send(16'h4200, 16'h4000);

    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if ($urandom_range(0, 7) == 0) ra[14:10] = 5'd0;
      if ($urandom_range(0, 7) == 0) rb[14:10] = 5'd0;
      send(ra, rb);
    end

    for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
    #1 done_req = 1'b1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its summary in time");
    $fatal(1);
  end

endmodule
